// File: rtl/banco_wr_ctrl_if.sv
// Bus interface for banco_wr_ctrl: keypad/clear request side plus bank write port
// and bell outputs. The controller uses the master modport, the environment the slave.
interface banco_wr_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 3
);
    logic              key_req;
    logic [ADDR_W-1:0] key_pos;
    logic [DATA_W-1:0] key_data;
    logic              clr_req;
    logic [DATA_W-1:0] clr_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              key_ack;
    logic              clr_done;
    logic              busy;
    logic              overrun;
    logic              beep_en;
    logic [ADDR_W-1:0] tone_sel;

    modport master (
        input  key_req, key_pos, key_data, clr_req, clr_data,
        output wr_en, wr_addr, wr_data, key_ack, clr_done, busy, overrun,
               beep_en, tone_sel
    );

    modport slave (
        output key_req, key_pos, key_data, clr_req, clr_data,
        input  wr_en, wr_addr, wr_data, key_ack, clr_done, busy, overrun,
               beep_en, tone_sel
    );
endinterface

// File: rtl/banco_wr_ctrl.sv
// Write-port controller for the colour register bank: keypad writes, clear-all
// sequencer and bell window. Optional beep counter enabled by macro BANCO_BEEP_EN.
module banco_wr_ctrl #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 3,
    parameter int BEEP_CYCLES = 5000000
) (
    input  logic clk,
    input  logic rst,
    banco_wr_ctrl_if.master bus
);
    typedef enum logic {IDLE, CLR_RUN} state_t;

    state_t            state;
    logic              key_q;
    logic              pending;
    logic [ADDR_W-1:0] hold_pos;
    logic [DATA_W-1:0] hold_data;
    logic [DATA_W-1:0] fill;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   cnt_nxt;
    logic              clr_last;
    logic              key_edge;
    logic              key_go;

    assign key_edge = bus.key_req & ~key_q;
    assign cnt_nxt  = cnt + 1'b1;
    // A pending key is written only from IDLE when no clear is starting.
    assign key_go   = (state == IDLE) & ~bus.clr_req & pending;
    assign bus.busy = (state == CLR_RUN) | pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            key_q        <= 1'b0;
            pending      <= 1'b0;
            hold_pos     <= '0;
            hold_data    <= '0;
            fill         <= '0;
            cnt          <= '0;
            clr_last     <= 1'b0;
            bus.wr_en    <= 1'b0;
            bus.wr_addr  <= '0;
            bus.wr_data  <= '0;
            bus.key_ack  <= 1'b0;
            bus.clr_done <= 1'b0;
            bus.overrun  <= 1'b0;
            bus.tone_sel <= '0;
        end else begin
            key_q        <= bus.key_req;
            bus.wr_en    <= 1'b0;
            bus.key_ack  <= 1'b0;
            clr_last     <= 1'b0;
            bus.clr_done <= clr_last;

            if (key_edge) begin
                if (pending) begin
                    bus.overrun <= 1'b1;
                end else begin
                    hold_pos  <= bus.key_pos;
                    hold_data <= bus.key_data;
                    pending   <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (bus.clr_req) begin
                        state <= CLR_RUN;
                        fill  <= bus.clr_data;
                        cnt   <= '0;
                    end else if (key_go) begin
                        bus.wr_en    <= 1'b1;
                        bus.wr_addr  <= hold_pos;
                        bus.wr_data  <= hold_data;
                        bus.key_ack  <= 1'b1;
                        bus.tone_sel <= hold_pos;
                        pending      <= 1'b0;
                    end
                end
                CLR_RUN: begin
                    bus.wr_en   <= 1'b1;
                    bus.wr_addr <= cnt[ADDR_W-1:0];
                    bus.wr_data <= fill;
                    cnt         <= cnt_nxt;
                    // Extra counter bit flags the write to the last address.
                    if (cnt_nxt[ADDR_W]) begin
                        state    <= IDLE;
                        clr_last <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BANCO_BEEP_EN
    localparam int BEEP_W = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;

    logic [BEEP_W-1:0] beep_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            beep_cnt    <= '0;
            bus.beep_en <= 1'b0;
        end else if (key_go) begin
            beep_cnt    <= BEEP_W'(BEEP_CYCLES - 1);
            bus.beep_en <= 1'b1;
        end else if (beep_cnt != '0) begin
            beep_cnt <= beep_cnt - 1'b1;
        end else begin
            bus.beep_en <= 1'b0;
        end
    end
`else
    logic beep_cfg_unused;

    assign beep_cfg_unused = (BEEP_CYCLES == 0);
    assign bus.beep_en     = 1'b0;
`endif
endmodule

// File: tb/tb_banco_wr_ctrl.sv
// Bench for banco_wr_ctrl: directed scenarios plus random keypad/clear traffic
// checked cycle by cycle against a transaction-level reference model.
module tb_banco_wr_ctrl;
    localparam int AW    = 4;
    localparam int DW    = 3;
    localparam int BC    = 10;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cycle    = 0;

    always #5 clk = ~clk;

    banco_wr_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    banco_wr_ctrl #(.ADDR_W(AW), .DATA_W(DW), .BEEP_CYCLES(BC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: clear tracked as writes remaining, bell as time since last ack.
    bit          m_prev_key;
    bit          m_pend;
    int          m_pend_pos, m_pend_data;
    int          m_clr_left;
    int          m_fill;
    bit          m_done_next;
    bit          m_has_ack;
    int          m_last_ack;
    int          e_wr_en, e_wr_addr, e_wr_data, e_key_ack, e_clr_done;
    int          e_busy, e_overrun, e_beep, e_tone;

    task automatic model_reset();
        m_prev_key = 0; m_pend = 0; m_pend_pos = 0; m_pend_data = 0;
        m_clr_left = 0; m_fill = 0; m_done_next = 0; m_has_ack = 0; m_last_ack = 0;
        e_wr_en = 0; e_wr_addr = 0; e_wr_data = 0; e_key_ack = 0; e_clr_done = 0;
        e_busy = 0; e_overrun = 0; e_beep = 0; e_tone = 0;
    endtask

    task automatic model_edge();
        bit pend_before;
        bit key_rise;
        if (rst) begin
            model_reset();
            return;
        end
        e_wr_en    = 0;
        e_key_ack  = 0;
        e_clr_done = m_done_next;
        m_done_next = 0;
        key_rise   = bus.key_req && !m_prev_key;
        m_prev_key = bus.key_req;
        pend_before = m_pend;
        if (m_clr_left > 0) begin
            e_wr_en   = 1;
            e_wr_addr = DEPTH - m_clr_left;
            e_wr_data = m_fill;
            m_clr_left--;
            if (m_clr_left == 0) m_done_next = 1;
        end else if (bus.clr_req) begin
            m_clr_left = DEPTH;
            m_fill     = int'(bus.clr_data);
        end else if (m_pend) begin
            e_wr_en    = 1;
            e_wr_addr  = m_pend_pos;
            e_wr_data  = m_pend_data;
            e_key_ack  = 1;
            e_tone     = m_pend_pos;
            m_pend     = 0;
            m_has_ack  = 1;
            m_last_ack = cycle;
        end
        if (key_rise) begin
            if (pend_before) begin
                e_overrun = 1;
            end else begin
                m_pend      = 1;
                m_pend_pos  = int'(bus.key_pos);
                m_pend_data = int'(bus.key_data);
            end
        end
        e_busy = (m_clr_left > 0 || m_pend) ? 1 : 0;
`ifdef BANCO_BEEP_EN
        e_beep = (m_has_ack && (cycle - m_last_ack) < BC) ? 1 : 0;
`else
        e_beep = 0;
`endif
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    task automatic check_all();
        chk("wr_en", 32'(bus.wr_en), 32'(e_wr_en));
        if (e_wr_en != 0) begin
            chk("wr_addr", 32'(bus.wr_addr), 32'(e_wr_addr));
            chk("wr_data", 32'(bus.wr_data), 32'(e_wr_data));
        end
        chk("key_ack", 32'(bus.key_ack), 32'(e_key_ack));
        chk("clr_done", 32'(bus.clr_done), 32'(e_clr_done));
        chk("busy", 32'(bus.busy), 32'(e_busy));
        chk("overrun", 32'(bus.overrun), 32'(e_overrun));
        chk("beep_en", 32'(bus.beep_en), 32'(e_beep));
        chk("tone_sel", 32'(bus.tone_sel), 32'(e_tone));
    endtask

    task automatic step();
        @(posedge clk);
        cycle++;
        model_edge();
        #1;
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press(input int pos, input int data, input int hold);
        bus.key_req  = 1'b1;
        bus.key_pos  = AW'(pos);
        bus.key_data = DW'(data);
        steps(hold);
        bus.key_req = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_wr_en"}, 32'(bus.wr_en), 0);
        chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 0);
        chk({tag, "_wr_data"}, 32'(bus.wr_data), 0);
        chk({tag, "_key_ack"}, 32'(bus.key_ack), 0);
        chk({tag, "_clr_done"}, 32'(bus.clr_done), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_overrun"}, 32'(bus.overrun), 0);
        chk({tag, "_beep_en"}, 32'(bus.beep_en), 0);
        chk({tag, "_tone_sel"}, 32'(bus.tone_sel), 0);
    endtask

    initial begin
        int  budget;
        bit  hit;
        int  wr_cnt;
        model_reset();
        bus.key_req = 1'b0; bus.key_pos = '0; bus.key_data = '0;
        bus.clr_req = 1'b0; bus.clr_data = '0;

        // Reset values
        rst = 1'b1;
        steps(3);
        check_zero("reset");
        rst = 1'b0;
        steps(2);

        // Single key press: pos 5, data 6
        press(5, 6, 1);
        step();
        chk("key5_wr_en", 32'(bus.wr_en), 1);
        chk("key5_wr_addr", 32'(bus.wr_addr), 5);
        chk("key5_wr_data", 32'(bus.wr_data), 6);
        chk("key5_key_ack", 32'(bus.key_ack), 1);
        chk("key5_tone", 32'(bus.tone_sel), 5);
        step();
        chk("key5_wr_en_low", 32'(bus.wr_en), 0);
        steps(12);

        // Clear with fill 0: count writes and done pulse
        bus.clr_req = 1'b1; bus.clr_data = '0;
        step();
        bus.clr_req = 1'b0;
        wr_cnt = 0;
        for (int i = 0; i < DEPTH; i++) begin
            step();
            if (bus.wr_en === 1'b1 && bus.wr_addr === AW'(i)) wr_cnt++;
        end
        chk("clr_write_count", 32'(wr_cnt), DEPTH);
        step();
        chk("clr_done_pulse", 32'(bus.clr_done), 1);
        steps(3);

        // Clear and key edge in the same cycle: key written in clr_done cycle
        bus.clr_req = 1'b1; bus.clr_data = 3'b101;
        bus.key_req = 1'b1; bus.key_pos = 4'd9; bus.key_data = 3'b011;
        step();
        bus.clr_req = 1'b0;
        steps(2);
        bus.key_req = 1'b0;
        steps(DEPTH - 2);
        step();
        chk("clr_key9_done", 32'(bus.clr_done), 1);
        chk("clr_key9_addr", 32'(bus.wr_addr), 9);
        chk("clr_key9_ack", 32'(bus.key_ack), 1);
        chk("clr_key9_overrun", 32'(bus.overrun), 0);
        steps(3);

        // Two key edges during a clear: second one is an overrun
        bus.clr_req = 1'b1; bus.clr_data = 3'b010;
        step();
        bus.clr_req = 1'b0;
        steps(2);
        press(2, 1, 2);
        steps(2);
        press(7, 4, 2);
        steps(DEPTH);
        chk("overrun_set", 32'(bus.overrun), 1);
        steps(4);

        // Reset while the clear is writing address 6
        bus.clr_req = 1'b1; bus.clr_data = 3'b111;
        step();
        bus.clr_req = 1'b0;
        hit = 0;
        budget = 40;
        while (!hit && budget > 0) begin
            step();
            budget--;
            if (e_wr_en != 0 && e_wr_addr == 6) hit = 1;
        end
        chk("reach_addr6", 32'(hit), 1);
        rst = 1'b1;
        step();
        check_zero("midclr_rst");
        rst = 1'b0;
        steps(DEPTH);

        // Bell window, then a retrigger four cycles after the first ack
        press(3, 2, 1);
        steps(4);
        press(11, 5, 1);
        steps(2 * BC);

        // Random keypad and clear traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0) bus.key_req = ~bus.key_req;
            bus.key_pos  = AW'($urandom);
            bus.key_data = DW'($urandom);
            bus.clr_req  = ($urandom_range(0, 39) == 0);
            bus.clr_data = DW'($urandom);
            rst          = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        bus.key_req = 1'b0;
        bus.clr_req = 1'b0;
        steps(DEPTH + 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/banco_wr_ctrl.md
# banco_wr_ctrl

Write-port controller for the 16-entry colour register bank. It arbitrates between keypad write requests and an internal clear-all sequencer. Every accepted write is issued as a single registered `wr_en` cycle toward the bank. It also produces the bell gating window and the tone index that select the buzzer PWM frequency. It sits between the debounced keypad decoder and the bank's write port (`addrW`/`RegWrite`).

## Interface
- `ADDR_W`, 4: bank address width; the bank depth is 2^ADDR_W.
- `DATA_W`, 3: colour word width (R, G, B).
- `BEEP_CYCLES`, 5000000: bell window length in clk cycles (100 ms at 50 MHz).

- `clk`  in  1  system clock; every register updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `key_req`  in  1  keypad key-valid level (held while the key is pressed); a rising edge is one request.
- `key_pos`  in  ADDR_W  keypad position; sampled on the `key_req` rising edge.
- `key_data`  in  DATA_W  colour to write; sampled with `key_pos`.
- `clr_req`  in  1  clear-all request; level-sampled, acted on only in IDLE.
- `clr_data`  in  DATA_W  fill value for a clear; sampled when the clear starts.
- `wr_en`  out  1  bank write strobe, registered.
- `wr_addr`  out  ADDR_W  bank write address, registered.
- `wr_data`  out  DATA_W  bank write data, registered.
- `key_ack`  out  1  one-cycle pulse, coincident with the `wr_en` cycle of a keypad write.
- `clr_done`  out  1  one-cycle pulse, in the cycle after the last clear write.
- `busy`  out  1  high while in CLR_RUN, or while a keypad write is pending.
- `overrun`  out  1  sticky; set when a key edge arrives while one is already pending; cleared only by `rst`.
- `beep_en`  out  1  bell gate; AND it with the PWM output.
- `tone_sel`  out  ADDR_W  address of the last keypad write; drives the PWM frequency select.

## Operation
- Reset values: all outputs are 0. State is IDLE, the pending flag is 0, the edge register `key_q` is 0, and the beep counter is 0.
- Edge detect: a request is `key_req & ~key_q`, where `key_q` is `key_req` delayed one cycle. On a request, if nothing is pending: capture `key_pos`/`key_data` into the hold register and set pending. If something is already pending: set `overrun` and keep the old hold register.
- FSM states: IDLE, CLR_RUN.
- IDLE:
  - If `clr_req` is high: go to CLR_RUN, latch `clr_data`, and load the address counter with 0. Clear takes priority over a pending key.
  - Otherwise, if a key is pending: issue one write from the hold register, pulse `key_ack`, clear pending, and load `tone_sel` with the written address.
- CLR_RUN:
  - Issue one write per cycle at addresses 0 to 2^ADDR_W−1, in order, all with the latched fill value.
  - After the write to the last address, return to IDLE and pulse `clr_done`.
  - `clr_req` is ignored in this state.
  - Key edges are still captured into the hold register and written after the clear completes.
- The address counter is ADDR_W+1 bits wide, so reaching the last address is detected without wrap-around ambiguity.
- No more than one write per cycle. Keypad and clear writes never coincide.
- Beep:
  - Each `key_ack` loads the counter with BEEP_CYCLES−1 and sets `beep_en`.
  - The counter decrements each cycle, and `beep_en` falls when it reaches 0.
  - A new `key_ack` during a window restarts the window.
- Reset mid-clear: the sequence aborts immediately and no further writes are issued. Bank entries already written keep the clear value.

## Timing
- Key press: the rising edge is sampled at edge k. `wr_en`, `key_ack` and `beep_en` are high after edge k+1 (IDLE, no clear). `wr_en` and `key_ack` are low again after edge k+2. Latency is 1 cycle from capture to write.
- Clear: `clr_req` is sampled at edge k. `wr_en` is high for exactly 2^ADDR_W cycles, after edges k+1 … k+16. `clr_done` is high after edge k+17.
- Key pending at clear end: the key write is issued after edge k+17, in the same cycle as `clr_done`.
- `busy` goes high the cycle after the request is seen and falls together with the last write of the operation.
- `tone_sel` changes only on `key_ack` cycles. `beep_en` stays high for BEEP_CYCLES cycles.

## Configuration
- `BANCO_BEEP_EN` defined: the beep counter is built and `beep_en` behaves as described above.
- `BANCO_BEEP_EN` undefined: there is no counter, `beep_en` is tied to 0, and `tone_sel` still updates.

## Test plan
- Reset, then `key_req` rises with pos=5, data=3'b110 → one cycle with `wr_en`=1, `wr_addr`=5, `wr_data`=6, `key_ack`=1; `tone_sel`=5.
- `clr_req` pulse with `clr_data`=0 → 16 consecutive writes to addresses 0..15, data 0; `clr_done` the cycle after address 15; `busy` high throughout.
- `clr_req` and a key edge (pos=9) in the same cycle → the full clear runs first, then the write to address 9 in the `clr_done` cycle; `overrun`=0.
- Two key edges (pos=2, then pos=7) during a clear → `overrun`=1; only address 2 is written after the clear.
- `rst` asserted at clear address 6 → next cycle `wr_en`=0 and all outputs 0; no write to address 7.
- With BEEP_CYCLES=10 and `BANCO_BEEP_EN` defined, one key press → `beep_en` high for exactly 10 cycles; a second press at cycle 4 extends it to cycle 14.
